sram_rw_arbiter: RTL and testbench

Controller that sequences and shares one single-port 4096×7 SRAM macro between an independent read requester and write requester. After reset it sweeps the array to zero, then grants the one RW port each cycle to the read or the write requester with 2-way round-robin on conflict. It returns read data with fixed one-cycle latency. It sits directly in front of the SRAM macro; requesters never drive the macro themselves.

---
 rtl/sram_arb_pkg.sv | 18 +
 rtl/sram_rw_arbiter_if.sv | 62 ++++++
 rtl/sram_rw_arbiter_rr_arb2.sv | 31 +++
 rtl/sram_rw_arbiter.sv | 129 ++++++++++++
 tb/tb_sram_rw_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the single-port SRAM read/write arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 7;
  localparam int DEF_DEPTH  = 4096;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } req_e;

endpackage

// File: rtl/sram_rw_arbiter_if.sv
// Requester, response and SRAM macro signals of the arbiter.
interface sram_rw_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 7
);

  logic              clear_req;
  logic              init_done;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_ready;
  logic              rd_resp_valid;
  logic [DATA_W-1:0] rd_resp_data;
  logic              wr_req_valid;
  logic [ADDR_W-1:0] wr_req_addr;
  logic [DATA_W-1:0] wr_req_data;
  logic              wr_req_ready;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  clear_req,
    input  rd_req_valid,
    input  rd_req_addr,
    input  wr_req_valid,
    input  wr_req_addr,
    input  wr_req_data,
    input  sram_rdata,
    output init_done,
    output rd_req_ready,
    output rd_resp_valid,
    output rd_resp_data,
    output wr_req_ready,
    output sram_en,
    output sram_wmode,
    output sram_addr,
    output sram_wdata
  );

  modport master (
    output clear_req,
    output rd_req_valid,
    output rd_req_addr,
    output wr_req_valid,
    output wr_req_addr,
    output wr_req_data,
    output sram_rdata,
    input  init_done,
    input  rd_req_ready,
    input  rd_resp_valid,
    input  rd_resp_data,
    input  wr_req_ready,
    input  sram_en,
    input  sram_wmode,
    input  sram_addr,
    input  sram_wdata
  );

endinterface

// File: rtl/sram_rw_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; rr_last remembers the last granted side.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       rd_valid,
  input  logic       wr_valid,
  output logic [1:0] grant
);

  req_e rr_last;

  always_comb begin
    grant     = '0;
    grant[RD] = en && rd_valid &&
                (!wr_valid || rr_last == WR);
    grant[WR] = en && wr_valid &&
                (!rd_valid || rr_last == RD);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_last <= WR;
    end else if (|grant) begin
      rr_last <= grant[WR] ? WR : RD;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Zero-sweeps a single-port SRAM after reset, then shares it between
// a read and a write requester with one-cycle read latency.
module sram_rw_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic          clock,
  input logic          reset,
  sram_rw_arbiter_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;
  logic              resp_q;
  logic [1:0]        grant;
  logic              arb_en;

  logic              en;
  logic              wmode;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wmode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign arb_en = (state_q == RUN) &&
                  !bus.clear_req && !reset;

  rr_arb2 u_arb (
    .clock    (clock),
    .reset    (reset),
    .en       (arb_en),
    .rd_valid (bus.rd_req_valid),
    .wr_valid (bus.wr_req_valid),
    .grant    (grant)
  );

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    en        = 1'b0;
    wmode     = wmode_q;
    addr      = addr_q;
    wdata     = wdata_q;
    unique case (state_q)
      INIT: begin
        en    = 1'b1;
        wmode = 1'b1;
        addr  = clr_ptr_q;
        wdata = '0;
        if (clr_ptr_q == LAST) begin
          state_d   = RUN;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end
      RUN: begin
        unique case (1'b1)
          bus.clear_req: begin
            state_d   = INIT;
            clr_ptr_d = '0;
          end
          grant[RD]: begin
            en    = 1'b1;
            wmode = 1'b0;
            addr  = bus.rd_req_addr;
          end
          grant[WR]: begin
            en    = 1'b1;
            wmode = 1'b1;
            addr  = bus.wr_req_addr;
            wdata = bus.wr_req_data;
          end
          default: ;
        endcase
      end
    endcase
    // Macro stays idle while reset is held, even though state is INIT.
    if (reset) begin
      en = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      clr_ptr_q <= '0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      resp_q    <= grant[RD];
    end
  end

  // Idle cycles replay the last driven macro inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wmode_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (en) begin
      wmode_q <= wmode;
      addr_q  <= addr;
      if (wmode) begin
        wdata_q <= wdata;
      end
    end
  end

  assign bus.sram_en       = en;
  assign bus.sram_wmode    = wmode;
  assign bus.sram_addr     = addr;
  assign bus.sram_wdata    = wdata;
  assign bus.rd_req_ready  = grant[RD];
  assign bus.wr_req_ready  = grant[WR];
  assign bus.init_done     = (state_q == RUN);
  assign bus.rd_resp_valid = resp_q;
  assign bus.rd_resp_data  = bus.sram_rdata;

endmodule

// File: tb/tb_sram_rw_arbiter.sv
// Self-checking bench: SRAM macro model plus array-based reference model.
module tb_sram_rw_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 7;
  localparam int DEPTH = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sram_rw_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_rw_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // SRAM macro: garbage at power-up, read data held until next read
  logic [DW-1:0] mem [DEPTH];
  bit seeded;
  always @(posedge clock) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      seeded <= 1'b1;
    end else if (bus.sram_en) begin
      if (bus.sram_wmode) mem[bus.sram_addr] <= bus.sram_wdata;
      else bus.sram_rdata <= mem[bus.sram_addr];
    end
  end

  int n_cmp;
  int n_bad;

  // reference model
  logic [DW-1:0] exp_mem [DEPTH];
  bit            m_run;
  int            m_ptr;
  bit            m_favor_wr;
  bit            m_pend;
  logic [DW-1:0] m_rdata;
  logic [AW-1:0] m_haddr;
  bit            m_hwmode;
  logic [DW-1:0] m_hwdata;
  logic [1:0]    d_grant;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rv, input logic [AW-1:0] ra,
                      input bit wv, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input bit clr);
    int g;
    bus.rd_req_valid = rv;
    bus.rd_req_addr  = ra;
    bus.wr_req_valid = wv;
    bus.wr_req_addr  = wa;
    bus.wr_req_data  = wd;
    bus.clear_req    = clr;
    @(negedge clock);
    d_grant = {bus.wr_req_ready, bus.rd_req_ready};
    check("resp_valid", bus.rd_resp_valid, m_pend);
    if (m_pend) check("resp_data", bus.rd_resp_data, m_rdata);
    m_pend = 1'b0;
    if (!m_run) begin
      check("init_done0", bus.init_done, 0);
      check("init_ready", d_grant, 0);
      check("init_en", bus.sram_en, 1);
      check("init_wmode", bus.sram_wmode, 1);
      check("init_addr", bus.sram_addr, m_ptr);
      check("init_wdata", bus.sram_wdata, 0);
      exp_mem[m_ptr] = '0;
      m_haddr  = AW'(m_ptr);
      m_hwmode = 1'b1;
      m_hwdata = '0;
      if (m_ptr == DEPTH - 1) begin
        m_run = 1'b1;
        m_ptr = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      check("init_done1", bus.init_done, 1);
      g = 0;
      if (!clr) begin
        if (rv && wv) g = m_favor_wr ? 2 : 1;
        else if (rv) g = 1;
        else if (wv) g = 2;
      end
      check("ready", d_grant, g);
      check("en", bus.sram_en, g != 0);
      if (g == 1) begin
        check("rd_wmode", bus.sram_wmode, 0);
        check("rd_addr", bus.sram_addr, ra);
        m_pend   = 1'b1;
        m_rdata  = exp_mem[ra];
        m_haddr  = ra;
        m_hwmode = 1'b0;
        m_favor_wr = 1'b1;
      end else if (g == 2) begin
        check("wr_wmode", bus.sram_wmode, 1);
        check("wr_addr", bus.sram_addr, wa);
        check("wr_wdata", bus.sram_wdata, wd);
        exp_mem[wa] = wd;
        m_haddr  = wa;
        m_hwmode = 1'b1;
        m_hwdata = wd;
        m_favor_wr = 1'b0;
      end else begin
        check("hold_addr", bus.sram_addr, m_haddr);
        check("hold_wmode", bus.sram_wmode, m_hwmode);
        check("hold_wdata", bus.sram_wdata, m_hwdata);
      end
      if (clr) begin
        m_run = 1'b0;
        m_ptr = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(0, '0, 0, '0, '0, 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    bus.rd_req_valid = 1'b1;
    bus.wr_req_valid = 1'b1;
    bus.clear_req    = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      check("rst_en", bus.sram_en, 0);
      check("rst_rdy", {bus.wr_req_ready, bus.rd_req_ready}, 0);
      check("rst_done", bus.init_done, 0);
      check("rst_resp", bus.rd_resp_valid, 0);
      @(posedge clock);
      #1;
    end
    reset      = 1'b0;
    m_run      = 1'b0;
    m_ptr      = 0;
    m_pend     = 1'b0;
    m_favor_wr = 1'b0;
  endtask

  task automatic sweep_noise(input int n);
    for (int i = 0; i < n; i++)
      step(1'($urandom), AW'($urandom), 1'($urandom),
           AW'($urandom), DW'($urandom), 1'($urandom));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.rd_req_addr = '0;
    bus.wr_req_addr = '0;
    bus.wr_req_data = '0;
    #1;
    do_reset(3);

    // full sweep with requesters and clear_req toggling underneath
    sweep_noise(DEPTH);

    step(0, '0, 1, 12'h123, 7'h5A, 0);
    step(1, 12'h123, 0, '0, '0, 0);
    check("wr_rd_0x5a", bus.rd_resp_data, 7'h5A);
    idle();
    step(1, 12'hFFF, 0, '0, '0, 0);
    check("rd_0xfff", bus.rd_resp_data, 7'h00);

    // a lone write leaves read favoured for the conflict run
    step(0, '0, 1, 12'h200, 7'h11, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, AW'(12'h200 + i), 1, AW'(12'h210 + i),
           DW'(i + 1), 0);
      check("rr_seq", d_grant, (i % 2 == 0) ? 1 : 2);
    end
    idle();

    for (int i = 0; i < 400; i++)
      step(1'($urandom), AW'(12'h100 + $urandom_range(0, 15)),
           1'($urandom), AW'(12'h100 + $urandom_range(0, 15)),
           DW'($urandom), 0);

    // clear while a read request is valid; earlier read still returns
    step(1, 12'h123, 0, '0, '0, 0);
    step(1, 12'h123, 1, 12'h123, 7'h33, 1);
    check("clr_grant", d_grant, 0);
    idle();
    check("clr_done", bus.init_done, 0);
    sweep_noise(2000 - 1);
    check("at_2000", bus.sram_addr, 2000);

    do_reset(2);
    sweep_noise(DEPTH);
    step(1, 12'h123, 0, '0, '0, 0);
    check("rd_after_clr", bus.rd_resp_data, 7'h00);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
